// File: rtl/pe_systolic_serial.sv
// Bit-serial MAC processing element: accepts an operand pair, forwards it to its neighbours, and emits a dot-product result.
// Define PE_SIGNED_EN to build the two's-complement variant; the default build is unsigned.
module pe_systolic_serial #(
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 2*BITWIDTH+4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BITWIDTH-1:0]  a,
  input  logic [BITWIDTH-1:0]  b,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [BITWIDTH-1:0]  pa,
  output logic [BITWIDTH-1:0]  pb,
  output logic                 pass_valid,
  output logic [ACC_WIDTH-1:0] c,
  output logic                 data_out_valid
);

  localparam int PW = 2*BITWIDTH;
  localparam int CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t                 state, state_nxt;
  logic [BITWIDTH-1:0]    a_reg;
  logic [BITWIDTH-1:0]    b_reg;
  logic                   last_reg;
  logic [CW-1:0]          cnt;
  logic signed [PW-1:0]        product;
  logic signed [ACC_WIDTH-1:0] acc;

  // One shifted partial product; the top multiplier bit carries negative weight in the signed build.
  function automatic logic signed [PW-1:0] pp_term(input logic [BITWIDTH-1:0] av,
                                                    input logic bit_set,
                                                    input logic [CW-1:0] idx);
    logic signed [PW-1:0] ext;
    logic signed [PW-1:0] shifted;
`ifdef PE_SIGNED_EN
    ext = {{BITWIDTH{av[BITWIDTH-1]}}, av};
`else
    ext = {{BITWIDTH{1'b0}}, av};
`endif
    shifted = ext << idx;
    if (!bit_set) return '0;
`ifdef PE_SIGNED_EN
    if (idx == CW'(BITWIDTH-1)) return -shifted;
`endif
    return shifted;
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] acc_ext(input logic signed [PW-1:0] p);
`ifdef PE_SIGNED_EN
    return ACC_WIDTH'(p);
`else
    return ACC_WIDTH'($unsigned(p));
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MUL;
      end
      MUL:     if (cnt == CW'(BITWIDTH-1)) state_nxt = ACC;
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_reg          <= '0;
      b_reg          <= '0;
      last_reg       <= 1'b0;
      cnt            <= '0;
      product        <= '0;
      acc            <= '0;
      pa             <= '0;
      pb             <= '0;
      pass_valid     <= 1'b0;
      c              <= '0;
      data_out_valid <= 1'b0;
    end else begin
      pass_valid     <= 1'b0;
      data_out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          a_reg      <= a;
          b_reg      <= b;
          last_reg   <= in_last;
          product    <= '0;
          cnt        <= '0;
          pa         <= a;
          pb         <= b;
          pass_valid <= 1'b1;
        end
        MUL: begin
          product <= product + pp_term(a_reg, b_reg[cnt], cnt);
          cnt     <= cnt + 1'b1;
        end
        ACC: begin
          if (last_reg) begin
            c              <= acc + acc_ext(product);
            data_out_valid <= 1'b1;
            acc            <= '0;
          end else begin
            acc <= acc + acc_ext(product);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_systolic_serial.sv
// Directed bench for pe_systolic_serial: a default-width PE plus a 16-bit-accumulator PE driven by the same stimulus.
module tb_pe_systolic_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a, b;
  logic        in_valid, in_last;
  logic        in_ready, pass_valid, data_out_valid;
  logic [7:0]  pa, pb;
  logic [19:0] c;
  logic        in_ready16, pass_valid16, dov16;
  logic [7:0]  pa16, pb16;
  logic [15:0] c16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pe_systolic_serial #(.BITWIDTH(8), .ACC_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .pa(pa), .pb(pb), .pass_valid(pass_valid),
    .c(c), .data_out_valid(data_out_valid)
  );

  pe_systolic_serial #(.BITWIDTH(8), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready16), .pa(pa16), .pb(pb16), .pass_valid(pass_valid16),
    .c(c16), .data_out_valid(dov16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair from IDLE, check the forwarded copy, then walk the fixed latency.
  task automatic do_pair(input logic [7:0] av, input logic [7:0] bv, input logic lst);
    int early_dov;
    int extra_pass;
    chk("ready_before_accept", in_ready, 1'b1);
    a = av; b = bv; in_last = lst; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pass_valid_pulse", pass_valid, 1'b1);
    chk("pa_mirror", pa, av);
    chk("pb_mirror", pb, bv);
    early_dov = 0;
    extra_pass = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k < 9 && data_out_valid) early_dov++;
      if (pass_valid) extra_pass++;
    end
    chk("no_early_dov", early_dov, 0);
    chk("no_extra_pass", extra_pass, 0);
    chk("dov_at_latency", data_out_valid, lst);
    chk("ready_after_acc", in_ready, 1'b1);
  endtask

  initial begin
    int pass_cnt;
    int busy_ready;
    rst = 1'b0; a = '0; b = '0; in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    chk("rst_c", c, 0);
    chk("rst_pa", pa, 0);
    chk("rst_pb", pb, 0);
    chk("rst_pass_valid", pass_valid, 0);
    chk("rst_dov", data_out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    tick();

    // Dot product 4+1+2+3
    do_pair(8'd4, 8'd1, 1'b0);
    do_pair(8'd1, 8'd1, 1'b0);
    do_pair(8'd2, 8'd1, 1'b0);
    do_pair(8'd3, 8'd1, 1'b1);
    chk("dot_c", c, 20'd10);
    tick();
    chk("dot_dov_single_pulse", data_out_valid, 0);
    chk("dot_c_hold", c, 20'd10);

`ifdef PE_SIGNED_EN
    do_pair(8'hFD, 8'd5, 1'b1);
    chk("signed_neg15", c, 20'hFFFF1);
    do_pair(8'h80, 8'h80, 1'b1);
    chk("signed_min_sq", c, 20'd16384);
`else
    do_pair(8'd255, 8'd255, 1'b1);
    chk("umax_c", c, 20'd65025);
    do_pair(8'd255, 8'd255, 1'b0);
    do_pair(8'd255, 8'd255, 1'b1);
    chk("wide_no_wrap", c, 20'd130050);
    chk("wrap16", c16, 16'd64514);
`endif

    // Backpressure: in_valid held high while data changes during the multiply
    chk("bp_ready_idle", in_ready, 1);
    a = 8'd7; b = 8'd9; in_last = 1'b1; in_valid = 1'b1;
    tick();
    chk("bp_first_pass", pass_valid, 1);
    chk("bp_first_pa", pa, 8'd7);
    a = 8'd100; b = 8'd100;
    pass_cnt = 0;
    busy_ready = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (pass_valid) pass_cnt++;
      if (k < 9 && in_ready) busy_ready++;
    end
    chk("bp_no_capture", pass_cnt, 0);
    chk("bp_ready_low", busy_ready, 0);
    chk("bp_dov", data_out_valid, 1);
    chk("bp_c", c, 20'd63);
    tick();
    in_valid = 1'b0;
    chk("bp_second_pass", pass_valid, 1);
    chk("bp_second_pa", pa, 8'd100);
    for (int k = 1; k <= 9; k++) tick();
    chk("bp_second_dov", data_out_valid, 1);
    chk("bp_second_c", c, 20'd10000);

    // Reset at E4 of a multiply, with a partial sum already in the accumulator
    do_pair(8'd9, 8'd9, 1'b0);
    a = 8'd5; b = 8'd5; in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("midrst_c", c, 0);
    chk("midrst_pa", pa, 0);
    chk("midrst_pb", pb, 0);
    chk("midrst_pass", pass_valid, 0);
    chk("midrst_dov", data_out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    rst = 1'b1;
    tick();
    do_pair(8'd2, 8'd3, 1'b1);
    chk("post_rst_c", c, 20'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
